mem_arb: RTL and testbench

- Arbitrates a single-port unified memory between two requesters: the instruction-fetch path (feeds ir) and the load/store data path (LOD/STR instructions).
- Sits between the control unit/pc/ir path and the memory array in the top-level sisc.
- Sequences each access through a fixed-latency memory cycle and returns the read data with a one-cycle done pulse.

---
 rtl/mem_arb_if.sv | 44 ++++
 rtl/mem_arb.sv | 123 ++++++++++++
 tb/tb_mem_arb.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_if.sv
// Handshake and memory-side signal bundle for the unified-memory arbiter.
interface mem_arb_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 32
);
    // Instruction-fetch requester
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_done;
    logic [DW-1:0] if_rdata;

    // Load/store requester
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_done;
    logic [DW-1:0] d_rdata;

    // Memory array side
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    // Arbiter view
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_done, if_rdata, d_gnt, d_done, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    // Requester/memory view
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_done, if_rdata, d_gnt, d_done, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arb.sv
// Two-requester arbiter for a single-port fixed-latency memory.
// Fetch and load/store paths alternate on ties; each access runs
// IDLE -> ACCESS (MEM_LAT cycles) -> DONE with a one-cycle done pulse.
module mem_arb #(
    parameter int unsigned AW      = 16,
    parameter int unsigned DW      = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic     clk,
    input  logic     rst_f,
    mem_arb_if.slave bus
);
    localparam int unsigned   CW       = 3;
    localparam logic [CW-1:0] LAST_CNT = CW'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e        state_q;
    logic [CW-1:0] lat_cnt_q;
    logic          last_d_q;    // 1 when the most recent grant went to the data path
    logic          if_gnt_q;
    logic          d_gnt_q;
    logic          if_done_q;
    logic          d_done_q;
    logic          mem_en_q;
    logic          mem_we_q;
    logic          busy_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] d_rdata_q;
    logic          pick_d_c;

    // Winner selection: a lone request wins, a tie goes to whoever was not served last
    assign pick_d_c = bus.d_req && (!bus.if_req || !last_d_q);

    // Access sequencer with registered grants, strobes and read-data capture
    always_ff @(posedge clk) begin
        if (rst_f) begin
            state_q     <= IDLE;
            lat_cnt_q   <= '0;
            last_d_q    <= 1'b0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if_done_q <= 1'b0;
                    d_done_q  <= 1'b0;
                    if (bus.if_req || bus.d_req) begin
                        state_q   <= ACCESS;
                        busy_q    <= 1'b1;
                        mem_en_q  <= 1'b1;
                        lat_cnt_q <= '0;
                        last_d_q  <= pick_d_c;
                        if (pick_d_c) begin
                            d_gnt_q     <= 1'b1;
                            mem_we_q    <= bus.d_we;
                            mem_addr_q  <= bus.d_addr;
                            mem_wdata_q <= bus.d_wdata;
                        end else begin
                            if_gnt_q    <= 1'b1;
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= bus.if_addr;
                            mem_wdata_q <= '0;
                        end
                    end
                end
                ACCESS: begin
                    lat_cnt_q <= lat_cnt_q + CW'(1);
                    if (lat_cnt_q == LAST_CNT) begin
                        if (!mem_we_q) begin
                            if (d_gnt_q) begin
                                d_rdata_q <= bus.mem_rdata;
                            end else begin
                                if_rdata_q <= bus.mem_rdata;
                            end
                        end
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    if_done_q <= if_gnt_q;
                    d_done_q  <= d_gnt_q;
                    if_gnt_q  <= 1'b0;
                    d_gnt_q   <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.if_gnt    = if_gnt_q;
    assign bus.if_done   = if_done_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_gnt     = d_gnt_q;
    assign bus.d_done    = d_done_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: a transaction-level model predicts every
// output from the time elapsed since each grant, plus directed literal checks.
module tb_mem_arb;
    localparam int L = 2;

    logic clk;
    logic rst_f;
    int   checks;
    int   errors;

    mem_arb_if #(.AW(16), .DW(32)) bus  ();
    mem_arb_if #(.AW(16), .DW(32)) bus1 ();
    mem_arb_if #(.AW(16), .DW(32)) bus7 ();

    mem_arb #(.AW(16), .DW(32), .MEM_LAT(2)) u_dut  (.clk(clk), .rst_f(rst_f), .bus(bus));
    mem_arb #(.AW(16), .DW(32), .MEM_LAT(1)) u_lat1 (.clk(clk), .rst_f(rst_f), .bus(bus1));
    mem_arb #(.AW(16), .DW(32), .MEM_LAT(7)) u_lat7 (.clk(clk), .rst_f(rst_f), .bus(bus7));

    // Memory array shared by all instances; reads are only valid during a read access
    logic [31:0] mem_arr   [256];
    logic [31:0] model_mem [256];

    assign bus.mem_rdata  = (bus.mem_en  && !bus.mem_we)  ? mem_arr[bus.mem_addr[7:0]]  : 32'hBAD0BAD0;
    assign bus1.mem_rdata = (bus1.mem_en && !bus1.mem_we) ? mem_arr[bus1.mem_addr[7:0]] : 32'hBAD0BAD0;
    assign bus7.mem_rdata = (bus7.mem_en && !bus7.mem_we) ? mem_arr[bus7.mem_addr[7:0]] : 32'hBAD0BAD0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic mem_write_step();
        if (bus.mem_en && bus.mem_we) mem_arr[bus.mem_addr[7:0]] = bus.mem_wdata;
    endtask
    always @(posedge clk) mem_write_step();

    // ---------------- transaction model ----------------
    bit          m_valid = 1'b0;
    bit          m_act;
    int          m_t;
    bit          m_isd;
    bit          m_we;
    bit          m_last_d;
    bit          m_fresh;
    logic [15:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_if_rd;
    logic [31:0] m_d_rd;

    task automatic model_step();
        if (rst_f) begin
            m_valid = 1'b1; m_act = 1'b0; m_t = 0; m_last_d = 1'b0; m_fresh = 1'b1;
            m_isd = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_if_rd = '0; m_d_rd = '0;
        end else if (m_valid) begin
            if (m_act) begin
                m_t = m_t + 1;
                if (m_t == L && !m_we) begin
                    if (m_isd) m_d_rd = model_mem[m_addr[7:0]];
                    else       m_if_rd = model_mem[m_addr[7:0]];
                end
                if (m_t == L + 2) m_act = 1'b0;
            end
            if (!m_act && (bus.if_req || bus.d_req)) begin
                if (bus.if_req && bus.d_req) m_isd = !m_last_d;
                else                         m_isd = bus.d_req;
                m_last_d = m_isd;
                m_act    = 1'b1;
                m_t      = 0;
                m_fresh  = 1'b0;
                m_we     = m_isd && bus.d_we;
                m_addr   = m_isd ? bus.d_addr : bus.if_addr;
                m_wdata  = m_isd ? bus.d_wdata : 32'h0;
                if (m_we) model_mem[m_addr[7:0]] = m_wdata;
            end
        end
    endtask
    always @(posedge clk) model_step();

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_step();
        logic e_if, e_d, e_en, e_we;
        e_if = m_act && !m_isd;
        e_d  = m_act &&  m_isd;
        e_en = m_act && (m_t < L);
        e_we = e_en && m_we;
        chk1("if_gnt",  bus.if_gnt,  e_if && (m_t <= L));
        chk1("d_gnt",   bus.d_gnt,   e_d  && (m_t <= L));
        chk1("if_done", bus.if_done, e_if && (m_t == L + 1));
        chk1("d_done",  bus.d_done,  e_d  && (m_t == L + 1));
        chk1("busy",    bus.busy,    m_act && (m_t <= L));
        chk1("mem_en",  bus.mem_en,  e_en);
        chk1("mem_we",  bus.mem_we,  e_we);
        chk("if_rdata", bus.if_rdata, m_if_rd);
        chk("d_rdata",  bus.d_rdata,  m_d_rd);
        if (e_en || m_fresh) chk("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
        if (e_we || m_fresh) chk("mem_wdata", bus.mem_wdata, m_wdata);
        chk1("gnt_excl",  bus.if_gnt  && bus.d_gnt,  1'b0);
        chk1("done_excl", bus.if_done && bus.d_done, 1'b0);
    endtask
    always @(negedge clk) if (m_valid) compare_step();

    // Raise one request at a negedge and wait (bounded) for its done pulse
    task automatic do_req(input bit is_d, input bit we, input logic [15:0] addr,
                          input logic [31:0] wd, output int waited);
        waited = 0;
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wd;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if ((is_d && bus.d_done) || (!is_d && bus.if_done)) begin
                waited = i;
                break;
            end
        end
        if (is_d) bus.d_req = 1'b0;
        else      bus.if_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   w;
        int   nd, nord, cnt;
        int   done_at [4];
        bit   ord     [8];
        bit   exp_ord [4];
        bit   prev_if, prev_d;
        int   n1, n7, c1, c7, e1, e7;

        checks = 0;
        errors = 0;
        exp_ord = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 256; i++) begin
            mem_arr[i]   = 32'h1000_0000 + 32'(i);
            model_mem[i] = 32'h1000_0000 + 32'(i);
        end
        mem_arr[4]   = 32'h8800_1000;
        model_mem[4] = 32'h8800_1000;
        bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
        bus1.if_req = 0; bus1.if_addr = 0; bus1.d_req = 0; bus1.d_we = 0; bus1.d_addr = 0; bus1.d_wdata = 0;
        bus7.if_req = 0; bus7.if_addr = 0; bus7.d_req = 0; bus7.d_we = 0; bus7.d_addr = 0; bus7.d_wdata = 0;
        rst_f = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_f = 1'b0;

        // Reset state
        chk1("rst_busy",   bus.busy,   1'b0);
        chk1("rst_mem_en", bus.mem_en, 1'b0);
        chk("rst_if_rdata", bus.if_rdata, 32'h0);

        // Fetch from 0x0004
        bus.if_req = 1'b1; bus.if_addr = 16'h0004;
        @(negedge clk);
        chk1("t1_gnt_c1", bus.if_gnt, 1'b1);
        chk1("t1_en_c1",  bus.mem_en, 1'b1);
        @(negedge clk);
        chk1("t1_en_c2",  bus.mem_en, 1'b1);
        @(negedge clk);
        chk1("t1_en_c3",  bus.mem_en, 1'b0);
        chk1("t1_done_c3", bus.if_done, 1'b0);
        @(negedge clk);
        chk1("t1_done_c4", bus.if_done, 1'b1);
        chk("t1_rdata", bus.if_rdata, 32'h8800_1000);
        chk1("t1_d_done", bus.d_done, 1'b0);
        chk("t1_d_rdata", bus.d_rdata, 32'h0);
        bus.if_req = 1'b0;
        @(negedge clk);

        // Store then load back
        do_req(1'b1, 1'b1, 16'h0010, 32'hDEAD_BEEF, w);
        chk("st_latency", 32'(w), 32'd4);
        chk("st_mem", mem_arr[16], 32'hDEAD_BEEF);
        chk("st_d_rdata", bus.d_rdata, 32'h0);
        @(negedge clk);
        do_req(1'b1, 1'b0, 16'h0010, 32'h0, w);
        chk("ld_latency", 32'(w), 32'd4);
        chk("ld_d_rdata", bus.d_rdata, 32'hDEAD_BEEF);
        @(negedge clk);

        // Continuous tie after reset: D, IF, D, IF
        rst_f = 1'b1;
        @(negedge clk);
        rst_f = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 16'h0008;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0020;
        nd = 0; nord = 0; prev_if = 1'b0; prev_d = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.d_gnt && !prev_d && nord < 8) begin ord[nord] = 1'b1; nord++; end
            if (bus.if_gnt && !prev_if && nord < 8) begin ord[nord] = 1'b0; nord++; end
            prev_d = bus.d_gnt; prev_if = bus.if_gnt;
            if (bus.if_done || bus.d_done) begin
                done_at[nd] = i;
                nd++;
                if (nd == 4) break;
            end
        end
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        chk("tie_grants", 32'(nord), 32'd4);
        chk("tie_dones", 32'(nd), 32'd4);
        for (int k = 0; k < 4; k++) chk1("tie_order", ord[k], exp_ord[k]);
        chk("tie_first_done", 32'(done_at[0]), 32'd4);
        for (int k = 1; k < 4; k++) chk("tie_spacing", 32'(done_at[k] - done_at[k-1]), 32'd4);
        chk("tie_d_rdata", bus.d_rdata, 32'h1000_0020);
        chk("tie_if_rdata", bus.if_rdata, 32'h1000_0008);
        @(negedge clk);

        // Reset in the middle of a load
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0030;
        @(negedge clk);
        @(negedge clk);
        rst_f = 1'b1;
        @(negedge clk);
        rst_f = 1'b0; bus.d_req = 1'b0;
        chk1("rst_mid_gnt", bus.d_gnt, 1'b0);
        chk1("rst_mid_en",  bus.mem_en, 1'b0);
        chk1("rst_mid_busy", bus.busy, 1'b0);
        chk("rst_mid_d_rdata", bus.d_rdata, 32'h0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.d_done) cnt++;
        end
        chk("rst_mid_no_done", 32'(cnt), 32'd0);
        do_req(1'b0, 1'b0, 16'h0004, 32'h0, w);
        chk("rst_after_fetch_lat", 32'(w), 32'd4);
        chk("rst_after_fetch", bus.if_rdata, 32'h8800_1000);
        @(negedge clk);

        // Fetch request withdrawn right after grant
        bus.if_req = 1'b1; bus.if_addr = 16'h0005;
        @(negedge clk);
        chk1("wd_gnt", bus.if_gnt, 1'b1);
        bus.if_req = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.if_done) cnt++;
        end
        chk("wd_done_cnt", 32'(cnt), 32'd1);
        chk1("wd_busy", bus.busy, 1'b0);
        chk("wd_rdata", bus.if_rdata, 32'h1000_0005);

        // MEM_LAT=1 and MEM_LAT=7 instances: latency, strobe length, capture hold
        bus1.d_req = 1'b1; bus1.d_addr = 16'h0030;
        bus7.d_req = 1'b1; bus7.d_addr = 16'h0030;
        n1 = 0; n7 = 0; c1 = 0; c7 = 0; e1 = 0; e7 = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus1.mem_en) e1++;
            if (bus7.mem_en) e7++;
            if (bus1.d_done) begin c1++; if (n1 == 0) n1 = i; bus1.d_req = 1'b0; end
            if (bus7.d_done) begin c7++; if (n7 == 0) n7 = i; bus7.d_req = 1'b0; end
        end
        chk("lat1_done_at", 32'(n1), 32'd3);
        chk("lat7_done_at", 32'(n7), 32'd9);
        chk("lat1_done_cnt", 32'(c1), 32'd1);
        chk("lat7_done_cnt", 32'(c7), 32'd1);
        chk("lat1_en_cycles", 32'(e1), 32'd1);
        chk("lat7_en_cycles", 32'(e7), 32'd7);
        chk("lat1_rdata_hold", bus1.d_rdata, 32'h1000_0030);
        chk("lat7_rdata_hold", bus7.d_rdata, 32'h1000_0030);
        chk1("lat1_busy", bus1.busy, 1'b0);
        chk1("lat7_busy", bus7.busy, 1'b0);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
